// File: rtl/fir_seq_pkg.sv
// Shared types and default constants for the FIR tap-queue sequencer.
package fir_seq_pkg;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        IDLE  = 2'd1,
        RUN   = 2'd2,
        FLUSH = 2'd3
    } seq_state_t;

    localparam int DEF_ADDR_W = 10;
    localparam int DEF_TAPS   = 1021;
    localparam int DEF_DECIM  = 2;
    localparam int DEF_RD_LAT = 1;

    // Saturating 8-bit increment used by the overrun statistics counter.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/fir_seq_ptr.sv
// Write-side bookkeeping for the tap queue: decimation phase, write pointer,
// fill counter, primed flag and the oldest-retained-sample address.
module fir_seq_ptr
    import fir_seq_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int TAPS   = DEF_TAPS,
    parameter int DECIM  = DEF_DECIM
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              smpl_vld,
    output logic              we,
    output logic [ADDR_W-1:0] wr_ptr,
    output logic [ADDR_W-1:0] old_ptr,
    output logic              primed,
    output logic              fill_done
);

    localparam int                PH_W      = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [PH_W-1:0]   PH_ZERO   = {PH_W{1'b0}};
    localparam logic [PH_W-1:0]   PH_ONE    = PH_W'(1);
    localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(DECIM - 1);
    localparam logic [ADDR_W-1:0] ONE_A     = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] TAPS_A    = ADDR_W'(TAPS);
    localparam logic [ADDR_W-1:0] LAST_FILL = ADDR_W'(TAPS - 1);

    logic [PH_W-1:0]   phase_q, phase_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] fill_cnt_q, fill_cnt_d;
    logic              primed_q, primed_d;
    logic              we_s;
    logic              fill_done_s;

    // Accept decision, pointer advance, fill counting and primed detection.
    always_comb begin
        phase_d    = phase_q;
        wr_ptr_d   = wr_ptr_q;
        fill_cnt_d = fill_cnt_q;
        we_s       = smpl_vld & (phase_q == PH_ZERO);
        // Phase zero is the accept slot; it is where reset leaves us.
        if (smpl_vld) begin
            if (phase_q == PH_LAST) begin
                phase_d = PH_ZERO;
            end else begin
                phase_d = phase_q + PH_ONE;
            end
        end else begin
            phase_d = phase_q;
        end
        if (we_s) begin
            wr_ptr_d = wr_ptr_q + ONE_A;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        // Fill counting stops once primed; primed is sticky until reset.
        fill_done_s = we_s & ~primed_q & (fill_cnt_q == LAST_FILL);
        if (we_s && !primed_q) begin
            fill_cnt_d = fill_cnt_q + ONE_A;
        end else begin
            fill_cnt_d = fill_cnt_q;
        end
        primed_d = primed_q | fill_done_s;
    end

    // Write-side state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_q    <= PH_ZERO;
            wr_ptr_q   <= {ADDR_W{1'b0}};
            fill_cnt_q <= {ADDR_W{1'b0}};
            primed_q   <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            wr_ptr_q   <= wr_ptr_d;
            fill_cnt_q <= fill_cnt_d;
            primed_q   <= primed_d;
        end
    end

    assign we        = we_s;
    assign wr_ptr    = wr_ptr_q;
    // Oldest retained sample, as seen after the write in this cycle lands.
    assign old_ptr   = wr_ptr_q + ONE_A - TAPS_A;
    assign primed    = primed_q;
    assign fill_done = fill_done_s;

endmodule

// File: rtl/fir_seq_ctrl.sv
// FIR tap-queue sequencer: per accepted sample, runs one TAPS-long read/MAC pass
// over the circular queue and the coefficient ROM, then strobes out_vld.
// Optional overrun statistics counter (ovr_cnt) is built when FIR_SEQ_STATS_EN is defined.
module fir_seq_ctrl
    import fir_seq_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int TAPS   = DEF_TAPS,
    parameter int DECIM  = DEF_DECIM,
    parameter int RD_LAT = DEF_RD_LAT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              smpl_vld,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [ADDR_W-1:0] raddr,
    output logic [ADDR_W-1:0] coeff_addr,
    output logic              acc_clr,
    output logic              acc_en,
    output logic              out_vld,
    output logic              busy,
    output logic              primed,
`ifdef FIR_SEQ_STATS_EN
    output logic              overrun,
    output logic [7:0]        ovr_cnt
`else
    output logic              overrun
`endif
);

    localparam int                FL_W     = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [FL_W-1:0]   FL_ZERO  = {FL_W{1'b0}};
    localparam logic [FL_W-1:0]   FL_ONE   = FL_W'(1);
    localparam logic [FL_W-1:0]   FL_LAST  = FL_W'(RD_LAT - 1);
    localparam logic [ADDR_W-1:0] ZERO_A   = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ONE_A    = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] LAST_TAP = ADDR_W'(TAPS - 1);

    logic              we_s;
    logic [ADDR_W-1:0] wr_ptr_s;
    logic [ADDR_W-1:0] old_ptr_s;
    logic              primed_s;
    logic              fill_done_s;
    logic              start_s;
    logic              ovr_wr_s;

    seq_state_t        state_q, state_d;
    logic [ADDR_W-1:0] tap_q, tap_d;
    logic [ADDR_W-1:0] raddr_q, raddr_d;
    logic [ADDR_W-1:0] old_q, old_d;
    logic [FL_W-1:0]   flush_q, flush_d;
    logic [RD_LAT-1:0] lat_q, lat_d;
    logic              acc_clr_q, acc_clr_d;
    logic              out_vld_q, out_vld_d;
    logic              busy_q, busy_d;
    logic              overrun_q, overrun_d;
`ifdef FIR_SEQ_STATS_EN
    logic [7:0]        ovr_cnt_q, ovr_cnt_d;
`endif

    fir_seq_ptr #(
        .ADDR_W (ADDR_W),
        .TAPS   (TAPS),
        .DECIM  (DECIM)
    ) u_ptr (
        .clk       (clk),
        .rst_n     (rst_n),
        .smpl_vld  (smpl_vld),
        .we        (we_s),
        .wr_ptr    (wr_ptr_s),
        .old_ptr   (old_ptr_s),
        .primed    (primed_s),
        .fill_done (fill_done_s)
    );

    // Pass sequencing: next state, tap/read addresses, flush timing and strobes.
    always_comb begin
        state_d   = state_q;
        tap_d     = tap_q;
        raddr_d   = raddr_q;
        old_d     = old_q;
        flush_d   = flush_q;
        acc_clr_d = 1'b0;
        out_vld_d = 1'b0;
        start_s   = 1'b0;
        // A write during RUN/FLUSH is stored but never restarts or queues a pass.
        ovr_wr_s  = we_s & ((state_q == RUN) | (state_q == FLUSH));
        case (state_q)
            FILL: begin
                if (fill_done_s) begin
                    start_s = 1'b1;
                end else begin
                    start_s = 1'b0;
                end
            end
            IDLE: begin
                if (we_s) begin
                    start_s = 1'b1;
                end else begin
                    start_s = 1'b0;
                end
            end
            RUN: begin
                if (tap_q == LAST_TAP) begin
                    state_d = FLUSH;
                    tap_d   = ZERO_A;
                    raddr_d = old_q;
                    flush_d = FL_ZERO;
                end else begin
                    tap_d   = tap_q + ONE_A;
                    raddr_d = raddr_q + ONE_A;
                end
            end
            FLUSH: begin
                if (flush_q == FL_LAST) begin
                    state_d   = IDLE;
                    out_vld_d = 1'b1;
                end else begin
                    flush_d = flush_q + FL_ONE;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
        if (start_s) begin
            state_d   = RUN;
            tap_d     = ZERO_A;
            raddr_d   = old_ptr_s;
            old_d     = old_ptr_s;
            acc_clr_d = 1'b1;
        end else begin
            acc_clr_d = 1'b0;
        end
        // acc_en is the RUN window delayed by the RAM/ROM read latency.
        lat_d    = {RD_LAT{1'b0}};
        lat_d[0] = (state_q == RUN);
        for (int i = 1; i < RD_LAT; i++) begin
            lat_d[i] = lat_q[i-1];
        end
        busy_d    = (state_d == RUN) | (state_d == FLUSH) | out_vld_d;
        overrun_d = overrun_q | ovr_wr_s;
`ifdef FIR_SEQ_STATS_EN
        if (ovr_wr_s) begin
            ovr_cnt_d = sat_inc8(ovr_cnt_q);
        end else begin
            ovr_cnt_d = ovr_cnt_q;
        end
`endif
    end

    // Sequencer registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= FILL;
            tap_q     <= {ADDR_W{1'b0}};
            raddr_q   <= {ADDR_W{1'b0}};
            old_q     <= {ADDR_W{1'b0}};
            flush_q   <= {FL_W{1'b0}};
            lat_q     <= {RD_LAT{1'b0}};
            acc_clr_q <= 1'b0;
            out_vld_q <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
`ifdef FIR_SEQ_STATS_EN
            ovr_cnt_q <= 8'h00;
`endif
        end else begin
            state_q   <= state_d;
            tap_q     <= tap_d;
            raddr_q   <= raddr_d;
            old_q     <= old_d;
            flush_q   <= flush_d;
            lat_q     <= lat_d;
            acc_clr_q <= acc_clr_d;
            out_vld_q <= out_vld_d;
            busy_q    <= busy_d;
            overrun_q <= overrun_d;
`ifdef FIR_SEQ_STATS_EN
            ovr_cnt_q <= ovr_cnt_d;
`endif
        end
    end

    assign we         = we_s;
    assign waddr      = wr_ptr_s;
    assign raddr      = raddr_q;
    assign coeff_addr = tap_q;
    assign acc_clr    = acc_clr_q;
    assign acc_en     = lat_q[RD_LAT-1];
    assign out_vld    = out_vld_q;
    assign busy       = busy_q;
    assign primed     = primed_s;
    assign overrun    = overrun_q;
`ifdef FIR_SEQ_STATS_EN
    assign ovr_cnt    = ovr_cnt_q;
`endif

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Directed bench for fir_seq_ctrl: instance A (ADDR_W=4, TAPS=5, DECIM=2, RD_LAT=1)
// and instance B (ADDR_W=4, TAPS=5, DECIM=1, RD_LAT=3).
module tb_fir_seq_ctrl;

    localparam int TP = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n_a, rst_n_b, sv_a, sv_b;
    logic       we_a, acc_clr_a, acc_en_a, out_vld_a, busy_a, primed_a, overrun_a;
    logic [3:0] waddr_a, raddr_a, coeff_a;
    logic       we_b, acc_clr_b, acc_en_b, out_vld_b, busy_b, primed_b, overrun_b;
    logic [3:0] waddr_b, raddr_b, coeff_b;
`ifdef FIR_SEQ_STATS_EN
    logic [7:0] ovr_cnt_a, ovr_cnt_b;
`endif

    fir_seq_ctrl #(.ADDR_W(4), .TAPS(5), .DECIM(2), .RD_LAT(1)) dut_a (
        .clk(clk), .rst_n(rst_n_a), .smpl_vld(sv_a), .we(we_a), .waddr(waddr_a),
        .raddr(raddr_a), .coeff_addr(coeff_a), .acc_clr(acc_clr_a), .acc_en(acc_en_a),
        .out_vld(out_vld_a), .busy(busy_a), .primed(primed_a),
`ifdef FIR_SEQ_STATS_EN
        .overrun(overrun_a), .ovr_cnt(ovr_cnt_a)
`else
        .overrun(overrun_a)
`endif
    );

    fir_seq_ctrl #(.ADDR_W(4), .TAPS(5), .DECIM(1), .RD_LAT(3)) dut_b (
        .clk(clk), .rst_n(rst_n_b), .smpl_vld(sv_b), .we(we_b), .waddr(waddr_b),
        .raddr(raddr_b), .coeff_addr(coeff_b), .acc_clr(acc_clr_b), .acc_en(acc_en_b),
        .out_vld(out_vld_b), .busy(busy_b), .primed(primed_b),
`ifdef FIR_SEQ_STATS_EN
        .overrun(overrun_b), .ovr_cnt(ovr_cnt_b)
`else
        .overrun(overrun_b)
`endif
    );

    // sel chooses which instance the generic steps drive and observe.
    logic sel = 1'b0;
    wire       we_m      = sel ? we_b      : we_a;
    wire [3:0] waddr_m   = sel ? waddr_b   : waddr_a;
    wire [3:0] raddr_m   = sel ? raddr_b   : raddr_a;
    wire [3:0] coeff_m   = sel ? coeff_b   : coeff_a;
    wire       acc_clr_m = sel ? acc_clr_b : acc_clr_a;
    wire       acc_en_m  = sel ? acc_en_b  : acc_en_a;
    wire       out_vld_m = sel ? out_vld_b : out_vld_a;
    wire       busy_m    = sel ? busy_b    : busy_a;
    wire       primed_m  = sel ? primed_b  : primed_a;
    wire       overrun_m = sel ? overrun_b : overrun_a;

    int         n_vec = 0;
    int         n_err = 0;
    logic [3:0] exp_wp;
    logic       ph;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // One clock cycle: drive smpl_vld after the edge, then check we/waddr.
    task automatic do_cycle(input logic sv);
        logic acc;
        @(posedge clk);
        #1;
        if (sel) sv_b = sv; else sv_a = sv;
        #1;
        acc = sv && (sel || !ph);
        chk("we", {7'd0, we_m}, {7'd0, acc});
        chk("waddr", {4'd0, waddr_m}, {4'd0, exp_wp});
        if (acc) exp_wp = exp_wp + 4'd1;
        if (sv && !sel) ph = ~ph;
    endtask

    // Checks the cycles k+1 .. k+TAPS+RD_LAT+1 after a pass-starting write.
    task automatic run_pass(input logic [3:0] old, input int inj_mask);
        int rl;
        logic [3:0] ea;
        rl = sel ? 3 : 1;
        for (int j = 1; j <= TP + rl + 1; j++) begin
            do_cycle(inj_mask[j]);
            if (j <= TP) begin
                ea = old + 4'(j - 1);
                chk("raddr", {4'd0, raddr_m}, {4'd0, ea});
                chk("coeff_addr", {4'd0, coeff_m}, 8'(j - 1));
            end else begin
                chk("coeff_addr_idle", {4'd0, coeff_m}, 8'd0);
            end
            chk("acc_clr", {7'd0, acc_clr_m}, {7'd0, (j == 1)});
            chk("acc_en", {7'd0, acc_en_m}, {7'd0, ((j >= rl + 1) && (j <= TP + rl))});
            chk("out_vld", {7'd0, out_vld_m}, {7'd0, (j == TP + rl + 1)});
            chk("busy", {7'd0, busy_m}, 8'd1);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_raddr"},   {4'd0, raddr_m}, 8'd0);
        chk({tag, "_coeff"},   {4'd0, coeff_m}, 8'd0);
        chk({tag, "_acc_clr"}, {7'd0, acc_clr_m}, 8'd0);
        chk({tag, "_acc_en"},  {7'd0, acc_en_m}, 8'd0);
        chk({tag, "_out_vld"}, {7'd0, out_vld_m}, 8'd0);
        chk({tag, "_busy"},    {7'd0, busy_m}, 8'd0);
        chk({tag, "_primed"},  {7'd0, primed_m}, 8'd0);
        chk({tag, "_overrun"}, {7'd0, overrun_m}, 8'd0);
`ifdef FIR_SEQ_STATS_EN
        chk({tag, "_ovr_cnt"}, sel ? ovr_cnt_b : ovr_cnt_a, 8'd0);
`endif
    endtask

    initial begin
        rst_n_a = 1'b0; rst_n_b = 1'b0; sv_a = 1'b0; sv_b = 1'b0;
        exp_wp = 4'd0; ph = 1'b0;

        // Reset state of instance A.
        do_cycle(1'b0);
        do_cycle(1'b0);
        chk_reset_state("rst_a");
        rst_n_a = 1'b1;

        // Test 1: 10 pulses 4 cycles apart; pulses 1,3,5,7,9 write 0..4.
        for (int n = 1; n <= 8; n++) begin
            do_cycle(1'b1);
            do_cycle(1'b0); do_cycle(1'b0); do_cycle(1'b0);
        end
        do_cycle(1'b1);
        chk("primed_before", {7'd0, primed_m}, 8'd0);
        run_pass(4'd0, 1 << 4);
        chk("primed_after", {7'd0, primed_m}, 8'd1);
        chk("overrun_t1", {7'd0, overrun_m}, 8'd0);
        do_cycle(1'b0);
        chk("busy_idle_t1", {7'd0, busy_m}, 8'd0);

        // Test 2: continue to 30 writes; passes wrap through the ring.
        for (int w = 6; w <= 30; w++) begin
            do_cycle(1'b1);
            run_pass(exp_wp - 4'd5, 1 << 3);
            do_cycle(1'b0);
            chk("busy_idle_t2", {7'd0, busy_m}, 8'd0);
            chk("out_vld_idle_t2", {7'd0, out_vld_m}, 8'd0);
        end
        chk("wp_after_30", {4'd0, waddr_m}, 8'd14);

        // Test 4: write exactly in the out_vld cycle starts the next pass.
        do_cycle(1'b1);
        run_pass(4'd10, (1 << 1) | (1 << 7));
        run_pass(4'd11, 0);
        do_cycle(1'b0);
        chk("overrun_t4", {7'd0, overrun_m}, 8'd0);
        chk("busy_idle_t4", {7'd0, busy_m}, 8'd0);

        // Test 3: accepted write 2 cycles into a pass -> overrun, single out_vld.
        do_cycle(1'b1);
        do_cycle(1'b0);
        do_cycle(1'b1);
        run_pass(4'd12, (1 << 1) | (1 << 2));
        do_cycle(1'b0);
        chk("out_vld_single_t3", {7'd0, out_vld_m}, 8'd0);
        chk("busy_idle_t3", {7'd0, busy_m}, 8'd0);
        chk("overrun_t3", {7'd0, overrun_m}, 8'd1);
        chk("waddr_adv_t3", {4'd0, waddr_m}, 8'd2);
`ifdef FIR_SEQ_STATS_EN
        chk("ovr_cnt_t3", ovr_cnt_a, 8'd1);
`endif

        // Test 5: one-cycle reset in the middle of RUN.
        do_cycle(1'b1);
        do_cycle(1'b0);
        do_cycle(1'b1);
        do_cycle(1'b0);
        chk("busy_mid_t5", {7'd0, busy_m}, 8'd1);
        do_cycle(1'b0);
        rst_n_a = 1'b0;
        exp_wp = 4'd0; ph = 1'b0;
        do_cycle(1'b0);
        chk_reset_state("rst_mid");
        rst_n_a = 1'b1;
        for (int c = 0; c < 8; c++) begin
            do_cycle(1'b0);
            chk("no_out_vld_t5", {7'd0, out_vld_m}, 8'd0);
        end
        for (int n = 1; n <= 4; n++) begin
            do_cycle(1'b1); do_cycle(1'b0);
            do_cycle(1'b1); do_cycle(1'b0);
        end
        do_cycle(1'b1);
        chk("primed_before_t5", {7'd0, primed_m}, 8'd0);
        run_pass(4'd0, 0);
        chk("primed_after_t5", {7'd0, primed_m}, 8'd1);

        // Test 6: instance B, DECIM=1 and RD_LAT=3.
        sel = 1'b1;
        exp_wp = 4'd0;
        do_cycle(1'b0);
        chk_reset_state("rst_b");
        rst_n_b = 1'b1;
        for (int n = 1; n <= 4; n++) begin
            do_cycle(1'b1);
        end
        do_cycle(1'b1);
        run_pass(4'd0, 0);
        do_cycle(1'b0);
        chk("busy_idle_b", {7'd0, busy_m}, 8'd0);
        chk("out_vld_idle_b", {7'd0, out_vld_m}, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
